fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 6 +
 rtl/fetch_queue.sv | 75 +++++++
 2 files changed

// File: rtl/fetch_queue_pkg.sv
// Constants shared by the fetch path: PC width and the NOP encoding
// that is emitted whenever the queue has nothing valid to present.
package fetch_queue_pkg;
  localparam int          WIDTH     = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode packet queue: head is visible one cycle after the push edge, and flush drops everything.
// in_ready falls only when the queue is full, and out_ready never frees a slot in that same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = WIDTH
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pc_plus_4,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_plus_4,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0) && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // DEPTH is a power of two, so pointer increments wrap for free.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      pc4_mem[wr_ptr]   <= in_pc_plus_4;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  assign out_pc        = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_pc_plus_4 = out_valid ? pc4_mem[rd_ptr]   : '0;
  assign out_instr     = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;

endmodule
